// File: rtl/ldpc_frame_scheduler.sv
// ----------------------------------------------------------------------------
// ldpc_frame_scheduler
//
// Sits between an LLR source and a 10-bit LDPC decoder. Collects one frame of
// channel LLRs (saturated to +/-LLR_MAX), presents the buffered frame to the
// decoder, then runs decoder iterations until the syndrome is clear or the
// iteration cap is reached. The corrected codeword is returned together with
// the number of iterations used and a convergence flag.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   in_valid/ready  LLR input handshake, one signed W-bit word per transfer,
//   in_llr          codeword index 0 first
//   dec_evidence    buffered saturated LLRs, word k at [k*W +: W]
//   dec_load        one-cycle pulse: decoder re-initialises from dec_evidence
//   dec_iter_en     one-cycle pulse: decoder runs one iteration
//   dec_bits        decoder hard decisions, valid ITER_CYCLES after dec_iter_en
//   dec_parity_ok   decoder syndrome all-zero, valid with dec_bits
//   out_valid/ready result handshake
//   out_bits        corrected codeword
//   out_iters       iterations used (1..MAX_ITER)
//   out_converged   1 = parity satisfied, 0 = iteration cap reached
// ----------------------------------------------------------------------------
module ldpc_frame_scheduler #(
    parameter int N           = 10,
    parameter int W           = 32,
    parameter int LLR_MAX     = 1000,
    parameter int MAX_ITER    = 20,
    parameter int ITER_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_llr,
    output logic [N*W-1:0]      dec_evidence,
    output logic                dec_load,
    output logic                dec_iter_en,
    input  logic [N-1:0]        dec_bits,
    input  logic                dec_parity_ok,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N-1:0]        out_bits,
    output logic [7:0]          out_iters,
    output logic                out_converged
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (ITER_CYCLES > 1) ? $clog2(ITER_CYCLES) : 1;

    localparam logic signed [W-1:0] LLR_POS   = W'(LLR_MAX);
    localparam logic signed [W-1:0] LLR_NEG   = -LLR_POS;
    localparam logic [IW-1:0]       IDX_LAST  = IW'(N - 1);
    localparam logic [CW-1:0]       WAIT_INIT = CW'(ITER_CYCLES - 1);
    localparam logic [7:0]          ITER_CAP  = 8'(MAX_ITER);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PRIME,
        ITER,
        WAIT,
        CHECK,
        OUTPUT
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [IW-1:0]        idx_q;
    logic [7:0]           iter_cnt_q;
    logic [CW-1:0]        wait_cnt_q;
    logic signed [W-1:0]  llr_buf [N];
    logic                 in_accept;
    logic                 check_done;

    // Clamp an incoming LLR to +/-LLR_MAX using a full-width signed compare,
    // so the most negative W-bit value also lands on -LLR_MAX.
    function automatic logic signed [W-1:0] sat(input logic signed [W-1:0] v);
        if (v > LLR_POS) begin
            return LLR_POS;
        end else if (v < LLR_NEG) begin
            return LLR_NEG;
        end
        return v;
    endfunction

    assign in_accept  = in_valid && in_ready;
    assign check_done = dec_parity_ok || (iter_cnt_q == ITER_CAP);

    // The evidence bus is a direct view of the frame buffer; the buffer only
    // changes on LOAD writes, so the decoder sees a stable frame from PRIME
    // until the next frame starts arriving.
    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_evidence
            assign dec_evidence[g*W +: W] = llr_buf[g];
        end
    endgenerate

    // State register. Reset returns to IDLE from anywhere, which drops any
    // frame or iteration in progress without producing a result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus the handshake and decoder strobes, which are
    // plain decodes of the registered state so they are glitch-free pulses
    // exactly one state long. Parity wins over the iteration cap in CHECK,
    // so converging on the final allowed iteration still reports success.
    always_comb begin
        state_d     = state_q;
        in_ready    = 1'b0;
        dec_load    = 1'b0;
        dec_iter_en = 1'b0;
        out_valid   = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (idx_q == IDX_LAST)) begin
                    state_d = PRIME;
                end
            end
            PRIME: begin
                dec_load = 1'b1;
                state_d  = ITER;
            end
            ITER: begin
                dec_iter_en = 1'b1;
                state_d     = WAIT;
            end
            WAIT: begin
                if (wait_cnt_q == '0) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = check_done ? OUTPUT : ITER;
            end
            OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: frame buffer writes, the word index, the iteration and wait
    // counters, and the result registers. The result registers are only
    // written in CHECK when the frame finishes, so they hold steady for the
    // whole time the consumer keeps out_ready low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q         <= '0;
            iter_cnt_q    <= '0;
            wait_cnt_q    <= '0;
            out_bits      <= '0;
            out_iters     <= '0;
            out_converged <= 1'b0;
            for (int k = 0; k < N; k++) begin
                llr_buf[k] <= '0;
            end
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_accept) begin
                        llr_buf[idx_q] <= sat(in_llr);
                        idx_q          <= (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
                    end
                end
                PRIME: begin
                    iter_cnt_q <= '0;
                end
                ITER: begin
                    iter_cnt_q <= iter_cnt_q + 8'd1;
                    wait_cnt_q <= WAIT_INIT;
                end
                WAIT: begin
                    if (wait_cnt_q != '0) begin
                        wait_cnt_q <= wait_cnt_q - CW'(1);
                    end
                end
                CHECK: begin
                    if (check_done) begin
                        out_bits      <= dec_bits;
                        out_iters     <= iter_cnt_q;
                        out_converged <= dec_parity_ok;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/ldpc_frame_scheduler.md
Name: ldpc_frame_scheduler

Overview:
Sequences the 10-bit LDPC Decoder for streamed frames.
- Accepts channel LLRs one word per handshake and buffers a full frame.
- Drives the buffered frame onto the decoder evidence bus, then issues decoder iterations until parity is satisfied or an iteration cap is hit.
- Returns the corrected codeword with iteration count and convergence flag over a valid/ready output.
- Sits between the LLR source (top level or channel front end) and the decoder instance.

Parameters:
N, 10, codeword length (LLRs per frame, decoded bits)
W, 32, signed LLR width
LLR_MAX, 1000, saturation magnitude applied to incoming LLRs (positive, < 2^(W-1))
MAX_ITER, 20, maximum decoder iterations per frame (1..255)
ITER_CYCLES, 4, clock cycles the decoder needs per iteration (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
in_valid  in  1  LLR word valid
in_ready  out  1  scheduler can accept an LLR word
in_llr  in  W  signed channel LLR, bit order index 0 first
dec_evidence  out  N*W  buffered saturated LLRs; word k at bits [k*W +: W]
dec_load  out  1  one-cycle pulse: decoder re-initialises beliefs from dec_evidence
dec_iter_en  out  1  one-cycle pulse: decoder runs one iteration
dec_bits  in  N  decoder corrected_seq, valid ITER_CYCLES cycles after dec_iter_en
dec_parity_ok  in  1  decoder syndrome all-zero, valid with dec_bits
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_bits  out  N  corrected codeword
out_iters  out  8  iterations used (1..MAX_ITER)
out_converged  out  1  1 = parity satisfied, 0 = cap reached

Behaviour:
Reset (asynchronous, any state):
- state = IDLE; idx, iter_cnt, wait_cnt = 0; LLR buffer = 0.
- All outputs 0: dec_evidence, dec_load, dec_iter_en, out_valid, out_bits, out_iters, out_converged.
- Reset mid-frame or mid-iteration aborts the frame. No partial result is emitted.

States (in_ready = 1 only in LOAD; dec_load, dec_iter_en and out_valid are registered state decodes):
- IDLE: go to LOAD next cycle unconditionally (first cycle after reset release).
- LOAD: on in_valid && in_ready, write sat(in_llr) to buffer[idx].
  - If idx == N-1: idx = 0 and go to PRIME. Otherwise idx++.
  - No accept: hold state and buffer.
- PRIME: dec_load = 1 for exactly 1 cycle; iter_cnt = 0; go to ITER.
- ITER: dec_iter_en = 1 for exactly 1 cycle; iter_cnt++; wait_cnt = ITER_CYCLES-1; go to WAIT.
- WAIT: if wait_cnt == 0, go to CHECK; else wait_cnt--. WAIT lasts ITER_CYCLES cycles.
- CHECK: sample dec_bits and dec_parity_ok.
  - If dec_parity_ok == 1, or iter_cnt == MAX_ITER: out_bits = dec_bits; out_iters = iter_cnt; out_converged = dec_parity_ok; go to OUTPUT.
  - Otherwise go to ITER.
  - dec_parity_ok takes priority, so converging on the last allowed iteration gives converged = 1.
- OUTPUT: out_valid = 1; hold out_bits, out_iters and out_converged stable. When out_ready is high, out_valid drops next cycle and the FSM goes to LOAD.
  - out_ready asserted before out_valid has no effect.

Saturation (sat):
- in_llr > LLR_MAX gives LLR_MAX; in_llr < -LLR_MAX gives -LLR_MAX; else unchanged.
- Compare signed at full W width. -2^(W-1) saturates to -LLR_MAX.

Decoder evidence bus:
- dec_evidence reflects the buffer continuously and is stable from PRIME until the next LOAD write.
- The decoder latches evidence on dec_load.

Latency (last LLR accept to out_valid rise):
- 1 (PRIME) + k*(ITER_CYCLES+2) cycles, where k = iterations used.
- Defaults: 7 cycles for k = 1; 121 cycles for k = MAX_ITER = 20.

Throughput:
- No frame overlap; in_ready = 0 from PRIME through the OUTPUT handshake.
- Backpressure on the output stalls input indefinitely.

Test Plan:
- Reset, then 10 LLRs {-13,13,13,13,-13,13,13,-13,13,-13} with in_valid held high -> 10 accepts in 10 consecutive cycles; dec_load pulses once 1 cycle after the 10th accept; dec_evidence word0 = -13, word9 = -13.
- Decoder model asserts parity_ok after iteration 1 with bits 0b0101101110 -> one dec_iter_en pulse; out_valid rises 7 cycles after the last accept; out_bits = 0b0101101110, out_iters = 1, out_converged = 1.
- Decoder model never asserts parity_ok -> exactly 20 dec_iter_en pulses, 6 cycles apart; out_iters = 20, out_converged = 0. Separately, parity_ok first at iteration 20 -> out_converged = 1.
- in_llr = 5000, -5000, and -2^31 -> buffered words 1000, -1000, -1000; in_llr = 999 is unchanged.
- out_ready held low for 50 cycles after out_valid -> out_* stable and in_ready = 0 throughout; a 1-cycle out_ready pulse drops out_valid next cycle and raises in_ready (LOAD).
- Assert rst during WAIT of iteration 3 -> all outputs 0 immediately; after release, in_ready = 1 one cycle later; a fresh 10-word frame decodes correctly with out_iters counted from 1.
